// File: rtl/systolic_pkg.sv
// Shared sizes, state encoding and element helper for the systolic operand feeder.
package systolic_pkg;
  localparam int N         = 3;
  localparam int ELEM_W    = 4;
  localparam int ROW_W     = N * ELEM_W;
  localparam int DRAIN_CYC = 3;
  localparam int FEED_CYC  = 2 * N - 1;
  localparam int CNT_W     = $clog2((FEED_CYC > DRAIN_CYC) ? FEED_CYC : DRAIN_CYC);
  localparam int DLY_W     = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Element k (1-based) of a packed word, counted from the MSB end.
  function automatic logic [ELEM_W-1:0] get_elem(input logic [ROW_W-1:0] w, input int k);
    return w[ROW_W-1-(k-1)*ELEM_W -: ELEM_W];
  endfunction
endpackage

// File: rtl/systolic_operand_lane.sv
// One edge lane: holds a captured row/column and emits it MSB-first after a fixed skew delay.
module systolic_operand_lane
  import systolic_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [DLY_W-1:0]  delay,
  input  logic [ROW_W-1:0]  word,
  output logic [ELEM_W-1:0] feed
);
  logic [ROW_W-1:0] sr;
  logic [DLY_W-1:0] dcnt;

  // Shifting zeros in behind the elements gives the trailing zero padding for free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr   <= '0;
      dcnt <= '0;
      feed <= '0;
    end else if (load) begin
      sr   <= word;
      dcnt <= delay;
      feed <= '0;
    end else if (shift) begin
      if (dcnt != '0) begin
        dcnt <= dcnt - 1'b1;
        feed <= '0;
      end else begin
        feed <= get_elem(sr, 1);
        sr   <= sr << ELEM_W;
      end
    end
  end
endmodule

// File: rtl/systolic_operand_feeder.sv
// Captures A rows / B columns on START, feeds them skewed into a 3x3 systolic array and sequences it.
module systolic_operand_feeder
  import systolic_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [ROW_W-1:0]  A_ROW1,
  input  logic [ROW_W-1:0]  A_ROW2,
  input  logic [ROW_W-1:0]  A_ROW3,
  input  logic [ROW_W-1:0]  B_COLOUM1,
  input  logic [ROW_W-1:0]  B_COLOUM2,
  input  logic [ROW_W-1:0]  B_COLOUM3,
  output logic [ELEM_W-1:0] A_FEED1,
  output logic [ELEM_W-1:0] A_FEED2,
  output logic [ELEM_W-1:0] A_FEED3,
  output logic [ELEM_W-1:0] B_FEED1,
  output logic [ELEM_W-1:0] B_FEED2,
  output logic [ELEM_W-1:0] B_FEED3,
  output logic              ARRAY_CLR,
  output logic              ARRAY_EN,
  output logic              BUSY,
  output logic              DONE
);
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             load;
  logic             shift;
  logic [ROW_W-1:0]  word [2*N];
  logic [ELEM_W-1:0] feed [2*N];

  assign word[0] = A_ROW1;
  assign word[1] = A_ROW2;
  assign word[2] = A_ROW3;
  assign word[3] = B_COLOUM1;
  assign word[4] = B_COLOUM2;
  assign word[5] = B_COLOUM3;

  // Lanes advance on the edges that enter each FEED cycle; the edge into DRAIN only shifts out zeros.
  assign load  = (state == ST_IDLE) && START;
  assign shift = (state == ST_CLEAR) || (state == ST_FEED);

  for (genvar g = 0; g < 2*N; g++) begin : g_lane
    systolic_operand_lane u_lane (
      .clk   (CLK),
      .rst   (RST),
      .load  (load),
      .shift (shift),
      .delay (DLY_W'(g % N)),
      .word  (word[g]),
      .feed  (feed[g])
    );
  end

  assign A_FEED1 = feed[0];
  assign A_FEED2 = feed[1];
  assign A_FEED3 = feed[2];
  assign B_FEED1 = feed[3];
  assign B_FEED2 = feed[4];
  assign B_FEED3 = feed[5];

  // Control outputs are set on the edge that enters the state they describe.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      ARRAY_CLR <= 1'b0;
      ARRAY_EN  <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      ARRAY_CLR <= 1'b0;
      DONE      <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (START) begin
            state     <= ST_CLEAR;
            cnt       <= '0;
            ARRAY_CLR <= 1'b1;
            ARRAY_EN  <= 1'b1;
            BUSY      <= 1'b1;
          end
        end
        ST_CLEAR: begin
          state <= ST_FEED;
          cnt   <= CNT_W'(FEED_CYC - 1);
        end
        ST_FEED: begin
          if (cnt == '0) begin
            state <= ST_DRAIN;
            cnt   <= CNT_W'(DRAIN_CYC - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DRAIN: begin
          if (cnt == '0) begin
            state <= ST_DONE;
            cnt   <= '0;
            DONE  <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          ARRAY_EN <= 1'b0;
          BUSY     <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          ARRAY_EN <= 1'b0;
          BUSY     <= 1'b0;
        end
      endcase
    end
  end
endmodule
